// File: rtl/eth_st_timing_adapter_buffered.sv
// eth_st_timing_adapter_buffered
// Avalon-ST timing adapter for a source that cannot be backpressured.
// A small elastic FIFO absorbs downstream stalls; words arriving while the
// FIFO is full (and not draining) are dropped and flagged via a sticky
// overflow bit.
// Optional build macro ETH_ST_TA_DROP_COUNT_EN adds a saturating 16-bit
// drop_count output, cleared together with overflow.

module eth_st_timing_adapter_buffered #(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      fill_level,
    output logic                  overflow,
    input  logic                  clr_overflow
`ifdef ETH_ST_TA_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop, drop;

    // Handshake decode and next-state for pointers, occupancy and overflow flag.
    // A full FIFO that is draining this cycle still accepts the new word.
    always_comb begin
        pop        = (count_q != '0) && out_ready;
        push       = in_valid && ((count_q < CNT_W'(DEPTH)) || pop);
        drop       = in_valid && !push;

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    // Control state registers; in-flight words are discarded on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Outputs come straight from registered state: no in_valid-to-out_valid path.
    always_comb begin
        out_data   = mem_q[rd_ptr_q];
        out_valid  = (count_q != '0);
        fill_level = count_q;
        overflow   = overflow_q;
    end

`ifdef ETH_ST_TA_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    // Saturating drop counter; a drop coinciding with a clear restarts at 1.
    always_comb begin
        drop_count_d = drop_count_q;
        if (clr_overflow)
            drop_count_d = drop ? 16'd1 : 16'd0;
        else if (drop && (drop_count_q != 16'hFFFF))
            drop_count_d = drop_count_q + 16'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_count_q <= 16'd0;
        else          drop_count_q <= drop_count_d;
    end

    // Drive the optional output port.
    always_comb begin
        drop_count = drop_count_q;
    end
`endif

endmodule

// File: tb/tb_eth_st_timing_adapter_buffered.sv
// Scoreboard bench for eth_st_timing_adapter_buffered.
// A reference model at each rising edge decides push/pop/drop and queues
// accepted words; a monitor on the falling edge compares status outputs with
// the model and pops/compares data on every output handshake.

module tb_eth_st_timing_adapter_buffered;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] fill_level;
    logic             overflow;
    logic             clr_overflow;
`ifdef ETH_ST_TA_DROP_COUNT_EN
    logic [15:0]      drop_count;
`endif

    eth_st_timing_adapter_buffered #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef ETH_ST_TA_DROP_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Model state
    logic [DW-1:0] exp_q[$];
    int            mcnt  = 0;
    bit            movf  = 1'b0;
    int            mdrop = 0;
    bit            mpush, mpop, mdrp;
    bit            mon_en = 1'b0;

    int npass  = 0;
    int ntotal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mcnt  = 0;
        movf  = 1'b0;
        mdrop = 0;
    endtask

    // Reference model: evaluated on the same edge the DUT samples.
    always @(posedge clk) begin
        if (reset_n) begin
            mpop  = (mcnt != 0) && out_ready;
            mpush = in_valid && ((mcnt < DEPTH) || mpop);
            mdrp  = in_valid && !mpush;
            if (mpush) exp_q.push_back(in_data);
            mcnt = mcnt + int'(mpush) - int'(mpop);
            if (mdrp) movf = 1'b1;
            else if (clr_overflow) movf = 1'b0;
            if (clr_overflow) mdrop = mdrp ? 1 : 0;
            else if (mdrp && mdrop != 16'hFFFF) mdrop++;
        end
    end

    // Monitor: status against model, data against scoreboard on handshake.
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            check("fill_level", 32'(fill_level), 32'(mcnt));
            check("out_valid", 32'(out_valid), 32'(mcnt != 0));
            check("overflow", 32'(overflow), 32'(movf));
`ifdef ETH_ST_TA_DROP_COUNT_EN
            check("drop_count", 32'(drop_count), 32'(mdrop));
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(out_data), 32'hDEAD_BEEF);
                end else begin
                    check("sb_data", 32'(out_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Apply inputs, let one rising edge consume them, return 1 time unit after it.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        in_valid     = v;
        in_data      = d;
        out_ready    = r;
        clr_overflow = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (mcnt != 0 && n < max_cycles) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_bound", 32'(mcnt == 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset with in_valid held, then a streaming run
        reset_n = 1'b0; in_valid = 1'b1; in_data = 16'h00EE; out_ready = 1'b1; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, DW'(k), 1'b1, 1'b0);
            check("t1_out_data", 32'(out_data), 32'(k));
            check("t1_out_valid", 32'(out_valid), 32'd1);
            check("t1_fill_le1", 32'(fill_level <= 1), 32'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("t1_empty", 32'(fill_level), 32'd0);
        check("t1_no_overflow", 32'(overflow), 32'd0);

        // Test 2: fill under backpressure, then drop one word
        for (int k = 0; k < 4; k++) step(1'b1, DW'(16'hA0 + k), 1'b0, 1'b0);
        check("t2_full", 32'(fill_level), 32'd4);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_head", 32'(out_data), 32'h00A0);
        step(1'b1, 16'h00A4, 1'b0, 1'b0);
        check("t2_full_after_drop", 32'(fill_level), 32'd4);
        check("t2_overflow", 32'(overflow), 32'd1);
`ifdef ETH_ST_TA_DROP_COUNT_EN
        check("t2_drop_count", 32'(drop_count), 32'd1);
`endif
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_order", 32'(out_data), 32'(16'hA0 + k));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("t2_drained", 32'(fill_level), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("t2_cleared", 32'(overflow), 32'd0);

        // Test 3: full FIFO with simultaneous pop accepts the new word
        for (int k = 1; k <= 4; k++) step(1'b1, DW'(16'hB0 + k), 1'b0, 1'b0);
        step(1'b1, 16'h00B5, 1'b1, 1'b0);
        check("t3_fill", 32'(fill_level), 32'd4);
        check("t3_no_drop", 32'(overflow), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            check("t3_order", 32'(out_data), 32'(16'hB0 + k));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("t3_drained", 32'(fill_level), 32'd0);

        // Test 5: asynchronous reset mid-burst at fill_level 3
        for (int k = 0; k < 3; k++) step(1'b1, DW'(16'hC0 + k), 1'b0, 1'b0);
        check("t5_pre_fill", 32'(fill_level), 32'd3);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_fill", 32'(fill_level), 32'd0);
        check("t5_async_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 16'h0055, 1'b0, 1'b0);
        check("t5_post_data", 32'(out_data), 32'h0055);
        check("t5_post_fill", 32'(fill_level), 32'd1);
        drain(10);

        // Test 6: drop coinciding with clear, then clear alone
        for (int k = 0; k < 4; k++) step(1'b1, DW'(16'hD0 + k), 1'b0, 1'b0);
        step(1'b1, 16'h00D4, 1'b0, 1'b0);
        check("t6_ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 16'h00D5, 1'b0, 1'b1);
        check("t6_ovf_set_wins", 32'(overflow), 32'd1);
`ifdef ETH_ST_TA_DROP_COUNT_EN
        check("t6_cnt_restart", 32'(drop_count), 32'd1);
`endif
        step(1'b0, '0, 1'b0, 1'b1);
        check("t6_ovf_clear", 32'(overflow), 32'd0);
`ifdef ETH_ST_TA_DROP_COUNT_EN
        check("t6_cnt_clear", 32'(drop_count), 32'd0);
`endif
        drain(10);

        // Test 4: random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 9) < 7), 1'b0);
        end
        drain(20);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
